// File: rtl/box_cmd_receiver.sv
// Box-draw command receiver: parses and validates box packets from the RX byte
// stream and publishes box coordinates/colours only at frame boundaries.
module box_cmd_receiver #(
    parameter int N_BOX = 1,
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int XW    = $clog2(H_ACT),
    parameter int YW    = $clog2(V_ACT)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                frame_start,
    output logic [N_BOX*XW-1:0] start_xs,
    output logic [N_BOX*YW-1:0] start_ys,
    output logic [N_BOX*XW-1:0] end_xs,
    output logic [N_BOX*YW-1:0] end_ys,
    output logic [N_BOX*24-1:0] colors,
    output logic                pkt_ok,
    output logic                pkt_err,
    output logic [15:0]         err_cnt
);

    localparam int unsigned NB   = N_BOX;
    localparam logic [7:0]  NMAX = 8'(N_BOX);
    localparam logic [11:0] HLIM = 12'(H_ACT);
    localparam logic [10:0] VLIM = 11'(V_ACT);

    typedef enum logic [2:0] {IDLE, CNT, DATA, CSUM, TAIL, DROP} state_t;

    // Matches the on-wire 48-bit record layout, MSB first.
    typedef struct packed {
        logic [10:0] sx;
        logic [9:0]  sy;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic [5:0]  col;
    } rec_t;

    typedef struct packed {
        logic [XW-1:0] sx;
        logic [YW-1:0] sy;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [23:0]   col;
    } box_t;

    function automatic box_t expand(input rec_t r);
        box_t b;
        b.sx  = XW'(r.sx);
        b.sy  = YW'(r.sy);
        b.ex  = XW'(r.ex);
        b.ey  = YW'(r.ey);
        b.col = {{4{r.col[5:4]}}, {4{r.col[3:2]}}, {4{r.col[1:0]}}};
        return b;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  k_q, k_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [39:0] asm_q, asm_d;
    logic [7:0]  xor_q, xor_d;
    logic        csum_ok_q, csum_ok_d;
    logic        bad_q, bad_d;
    logic        pending_q, pending_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic        pkt_err_q, pkt_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    rec_t        work_q [NB];
    rec_t        work_d [NB];
    box_t        shadow_q [NB];
    box_t        shadow_d [NB];
    box_t        out_q [NB];
    box_t        out_d [NB];

    rec_t rec_new;
    logic rec_ok;
    logic accept;
    logic reject;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        xor_d     = xor_q;
        csum_ok_d = csum_ok_q;
        bad_d     = bad_q;
        work_d    = work_q;
        accept    = 1'b0;
        reject    = 1'b0;

        rec_new = rec_t'({asm_q, rx_data});
        rec_ok  = (rec_new.sx <= rec_new.ex) && ({1'b0, rec_new.ex} < HLIM) &&
                  (rec_new.sy <= rec_new.ey) && ({1'b0, rec_new.ey} < VLIM);

        case (state_q)
            IDLE: begin
                if (rx_valid) state_d = (rx_data == 8'hA5) ? CNT : DROP;
            end
            CNT: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end else begin
                    n_d    = rx_data;
                    xor_d  = rx_data;
                    k_d    = '0;
                    bcnt_d = '0;
                    bad_d  = 1'b0;
                    state_d = (rx_data == 8'd0 || rx_data > NMAX) ? DROP : DATA;
                end
            end
            DATA: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end else begin
                    xor_d = xor_q ^ rx_data;
                    asm_d = {asm_q[31:0], rx_data};
                    if (bcnt_q == 3'd5) begin
                        bcnt_d = '0;
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (k_q == 8'(i)) work_d[i] = rec_new;
                        end
                        if (!rec_ok) bad_d = 1'b1;
                        k_d = k_q + 8'd1;
                        if (k_q == n_q - 8'd1) state_d = CSUM;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
            CSUM: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end else begin
                    csum_ok_d = (rx_data == xor_q);
                    state_d   = TAIL;
                end
            end
            TAIL: begin
                if (rx_valid) begin
                    state_d = DROP;
                end else begin
                    accept  = csum_ok_q && !bad_q;
                    reject  = !(csum_ok_q && !bad_q);
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commit reads shadow_q before an accept in the same cycle overwrites it,
    // so a coincident accept stays pending for the following frame.
    always_comb begin
        shadow_d  = shadow_q;
        out_d     = out_q;
        pending_d = pending_q;
        pkt_ok_d  = accept;
        pkt_err_d = reject;
        err_cnt_d = err_cnt_q;

        if (frame_start && pending_q) begin
            out_d     = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            for (int unsigned i = 0; i < NB; i++) begin
                shadow_d[i] = (8'(i) < n_q) ? expand(work_q[i]) : '0;
            end
            pending_d = 1'b1;
        end
        if (reject && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            n_q       <= '0;
            k_q       <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            xor_q     <= '0;
            csum_ok_q <= 1'b0;
            bad_q     <= 1'b0;
            pending_q <= 1'b0;
            pkt_ok_q  <= 1'b0;
            pkt_err_q <= 1'b0;
            err_cnt_q <= '0;
            work_q    <= '{default: '0};
            shadow_q  <= '{default: '0};
            out_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            xor_q     <= xor_d;
            csum_ok_q <= csum_ok_d;
            bad_q     <= bad_d;
            pending_q <= pending_d;
            pkt_ok_q  <= pkt_ok_d;
            pkt_err_q <= pkt_err_d;
            err_cnt_q <= err_cnt_d;
            work_q    <= work_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        start_xs = '0;
        start_ys = '0;
        end_xs   = '0;
        end_ys   = '0;
        colors   = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            start_xs[i*XW +: XW] = out_q[i].sx;
            start_ys[i*YW +: YW] = out_q[i].sy;
            end_xs[i*XW +: XW]   = out_q[i].ex;
            end_ys[i*YW +: YW]   = out_q[i].ey;
            colors[i*24 +: 24]   = out_q[i].col;
        end
    end

    assign pkt_ok  = pkt_ok_q;
    assign pkt_err = pkt_err_q;
    assign err_cnt = err_cnt_q;

endmodule
